// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard unit signal bundle: ID-stage operand/destination info,
// MEM-stage redirect, and the stall/flush controls plus status counters.
interface hazard_ctrl_if;
   logic        id_valid;
   logic [4:0]  id_ra;
   logic [4:0]  id_rb;
   logic        id_use_ra;
   logic        id_use_rb;
   logic        id_regwr;
   logic [4:0]  id_rw;
   logic        mem_redirect;
   logic        pc_hold;
   logic        ifid_hold;
   logic        idex_bubble;
   logic        ifid_flush;
   logic        exmem_flush;
   logic [1:0]  state;
   logic [15:0] stall_cycles;
   logic [15:0] redirects;

   modport master (
      output id_valid, id_ra, id_rb, id_use_ra, id_use_rb, id_regwr, id_rw, mem_redirect,
      input  pc_hold, ifid_hold, idex_bubble, ifid_flush, exmem_flush, state,
             stall_cycles, redirects
   );

   modport slave (
      input  id_valid, id_ra, id_rb, id_use_ra, id_use_rb, id_regwr, id_rw, mem_redirect,
      output pc_hold, ifid_hold, idex_bubble, ifid_flush, exmem_flush, state,
             stall_cycles, redirects
   );
endinterface

// File: rtl/hazard_ctrl.sv
// RAW-hazard and redirect controller for a 5-stage pipeline without a register-file
// bypass: destination-tag scoreboard over EX/MEM/WB, stall/flush controls, event counters.
module hazard_ctrl (
   input logic         clk,
   input logic         rst,
   hazard_ctrl_if.slave hz
);
   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_REDIR = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic        r_ex_v, r_mem_v, r_wb_v;
   logic [4:0]  r_ex_rd, r_mem_rd, r_wb_rd;
   logic [15:0] r_stall_cnt;
   logic [15:0] r_redir_cnt;

   logic        w_hit_ra, w_hit_rb, w_hit;
   logic        w_ex_v_nxt;
   logic        w_pc_hold, w_ifid_hold, w_idex_bubble, w_ifid_flush, w_exmem_flush;

   // WB is still a live producer: the register file is written at the end of WB.
   assign w_hit_ra = hz.id_use_ra && (hz.id_ra != '0) &&
                     ((r_ex_v  && (r_ex_rd  == hz.id_ra)) ||
                      (r_mem_v && (r_mem_rd == hz.id_ra)) ||
                      (r_wb_v  && (r_wb_rd  == hz.id_ra)));
   assign w_hit_rb = hz.id_use_rb && (hz.id_rb != '0) &&
                     ((r_ex_v  && (r_ex_rd  == hz.id_rb)) ||
                      (r_mem_v && (r_mem_rd == hz.id_rb)) ||
                      (r_wb_v  && (r_wb_rd  == hz.id_rb)));
   assign w_hit    = hz.id_valid && (w_hit_ra || w_hit_rb);

   assign w_ex_v_nxt = hz.id_valid && hz.id_regwr && (hz.id_rw != '0) &&
                       !w_hit && !hz.mem_redirect;

   always_comb begin
      w_pc_hold     = 1'b0;
      w_ifid_hold   = 1'b0;
      w_idex_bubble = 1'b0;
      w_ifid_flush  = 1'b0;
      w_exmem_flush = 1'b0;
      w_state_nxt   = ST_RUN;
      if (hz.mem_redirect) begin
         w_ifid_flush  = 1'b1;
         w_idex_bubble = 1'b1;
         w_exmem_flush = 1'b1;
         w_state_nxt   = ST_REDIR;
      end else if (w_hit) begin
         w_pc_hold     = 1'b1;
         w_ifid_hold   = 1'b1;
         w_idex_bubble = 1'b1;
         w_state_nxt   = ST_STALL;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // The instruction in MEM during a redirect is the branch itself and carries on to WB.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ex_v   <= 1'b0;
         r_ex_rd  <= '0;
         r_mem_v  <= 1'b0;
         r_mem_rd <= '0;
         r_wb_v   <= 1'b0;
         r_wb_rd  <= '0;
      end else begin
         r_ex_v   <= w_ex_v_nxt;
         r_ex_rd  <= hz.id_rw;
         r_mem_v  <= r_ex_v && !hz.mem_redirect;
         r_mem_rd <= r_ex_rd;
         r_wb_v   <= r_mem_v;
         r_wb_rd  <= r_mem_rd;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stall_cnt <= '0;
         r_redir_cnt <= '0;
      end else begin
         if (w_pc_hold && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
         end
         if (hz.mem_redirect && (r_redir_cnt != '1)) begin
            r_redir_cnt <= r_redir_cnt + 16'd1;
         end
      end
   end

   assign hz.pc_hold      = w_pc_hold;
   assign hz.ifid_hold    = w_ifid_hold;
   assign hz.idex_bubble  = w_idex_bubble;
   assign hz.ifid_flush   = w_ifid_flush;
   assign hz.exmem_flush  = w_exmem_flush;
   assign hz.state        = r_state;
   assign hz.stall_cycles = r_stall_cnt;
   assign hz.redirects    = r_redir_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a sequential vector table plus hand-written
// sequences for asynchronous reset and stall-counter saturation.
module tb_hazard_ctrl;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   hazard_ctrl_if hif ();

   hazard_ctrl dut (
      .clk (clk),
      .rst (rst),
      .hz  (hif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ctrl = {pc_hold, ifid_hold, idex_bubble, ifid_flush, exmem_flush}
   typedef struct {
      logic        valid;
      logic [4:0]  ra;
      logic [4:0]  rb;
      logic        use_ra;
      logic        use_rb;
      logic        regwr;
      logic [4:0]  rw;
      logic        redir;
      logic [4:0]  ctrl;
      logic [1:0]  state;
      logic [15:0] stalls;
      logic [15:0] redirs;
   } vec_t;

   vec_t vecs [27];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic valid, input logic [4:0] ra, input logic [4:0] rb,
                        input logic use_ra, input logic use_rb, input logic regwr,
                        input logic [4:0] rw, input logic redir);
      hif.id_valid     = valid;
      hif.id_ra        = ra;
      hif.id_rb        = rb;
      hif.id_use_ra    = use_ra;
      hif.id_use_rb    = use_rb;
      hif.id_regwr     = regwr;
      hif.id_rw        = rw;
      hif.mem_redirect = redir;
   endtask

   function automatic logic [4:0] ctrl_now();
      return {hif.pc_hold, hif.ifid_hold, hif.idex_bubble, hif.ifid_flush, hif.exmem_flush};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_vec(input int idx, input logic valid, input logic [4:0] ra,
                          input logic [4:0] rb, input logic use_ra, input logic use_rb,
                          input logic regwr, input logic [4:0] rw, input logic redir,
                          input logic [4:0] ctrl, input logic [1:0] st,
                          input logic [15:0] stalls, input logic [15:0] redirs);
      vecs[idx] = '{valid, ra, rb, use_ra, use_rb, regwr, rw, redir, ctrl, st, stalls, redirs};
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;

      //           idx v  ra  rb  ua ub wr rw  rd  ctrl      st   stl  rdr
      set_vec( 0, 0, 0,  0,  0, 0, 0, 0,  0, 5'b00000, 0, 0, 0); // idle
      set_vec( 1, 1, 0,  0,  0, 0, 1, 8,  0, 5'b00000, 0, 0, 0); // producer $8
      set_vec( 2, 1, 8,  0,  1, 0, 0, 0,  0, 5'b11100, 0, 0, 0); // EX hit
      set_vec( 3, 1, 8,  0,  1, 0, 0, 0,  0, 5'b11100, 1, 1, 0); // MEM hit
      set_vec( 4, 1, 8,  0,  1, 0, 0, 0,  0, 5'b11100, 1, 2, 0); // WB hit
      set_vec( 5, 1, 8,  0,  1, 0, 0, 0,  0, 5'b00000, 1, 3, 0); // released
      set_vec( 6, 0, 0,  0,  0, 0, 0, 0,  0, 5'b00000, 0, 3, 0);
      set_vec( 7, 1, 0,  0,  0, 0, 1, 0,  0, 5'b00000, 0, 3, 0); // producer $0
      set_vec( 8, 1, 0,  0,  1, 1, 0, 0,  0, 5'b00000, 0, 3, 0); // reads $0
      set_vec( 9, 1, 0,  0,  0, 0, 1, 5,  0, 5'b00000, 0, 3, 0); // producer $5
      set_vec(10, 0, 0,  5,  0, 1, 0, 0,  0, 5'b00000, 0, 3, 0); // invalid ID
      set_vec(11, 1, 3,  5,  1, 0, 0, 0,  0, 5'b00000, 0, 3, 0); // rb not used
      set_vec(12, 1, 0,  5,  0, 1, 0, 0,  0, 5'b11100, 0, 3, 0); // WB hit on rb
      set_vec(13, 1, 0,  5,  0, 1, 0, 0,  0, 5'b00000, 1, 4, 0);
      set_vec(14, 1, 0,  0,  0, 0, 1, 7,  0, 5'b00000, 0, 4, 0); // producer $7
      set_vec(15, 1, 7,  0,  1, 0, 1, 10, 1, 5'b00111, 0, 4, 0); // hit + redirect
      set_vec(16, 1, 7,  0,  1, 0, 0, 0,  0, 5'b00000, 2, 4, 1); // EX/MEM squashed
      set_vec(17, 0, 0,  0,  0, 0, 0, 0,  0, 5'b00000, 0, 4, 1);
      set_vec(18, 1, 0,  0,  0, 0, 1, 31, 0, 5'b00000, 0, 4, 1); // jal $31
      set_vec(19, 1, 0,  0,  0, 0, 1, 12, 0, 5'b00000, 0, 4, 1); // slot writes $12
      set_vec(20, 1, 0,  0,  0, 0, 1, 13, 1, 5'b00111, 0, 4, 1); // jal redirect in MEM
      set_vec(21, 1, 31, 12, 1, 1, 0, 0,  0, 5'b11100, 2, 4, 2); // $31 in WB
      set_vec(22, 1, 31, 12, 1, 1, 0, 0,  0, 5'b00000, 1, 5, 2); // retired
      set_vec(23, 0, 0,  0,  0, 0, 0, 0,  1, 5'b00111, 0, 5, 2); // redirect
      set_vec(24, 0, 0,  0,  0, 0, 0, 0,  1, 5'b00111, 2, 5, 3); // reasserted
      set_vec(25, 0, 0,  0,  0, 0, 0, 0,  0, 5'b00000, 2, 5, 4);
      set_vec(26, 0, 0,  0,  0, 0, 0, 0,  0, 5'b00000, 0, 5, 4);

      // Reset with a dependency pattern on the inputs: empty scoreboard means no stall.
      rst = 1'b0;
      drive(1, 8, 8, 1, 1, 1, 8, 0);
      #12;
      check("reset_ctrl",   16'(ctrl_now()), 16'd0);
      check("reset_state",  16'(hif.state), 16'd0);
      check("reset_stalls", hif.stall_cycles, 16'd0);
      check("reset_redirs", hif.redirects, 16'd0);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b1;
      tick();

      for (int i = 0; i < 27; i++) begin
         drive(vecs[i].valid, vecs[i].ra, vecs[i].rb, vecs[i].use_ra, vecs[i].use_rb,
               vecs[i].regwr, vecs[i].rw, vecs[i].redir);
         #1;
         check($sformatf("v%0d_ctrl", i),   16'(ctrl_now()), 16'(vecs[i].ctrl));
         check($sformatf("v%0d_state", i),  16'(hif.state), 16'(vecs[i].state));
         check($sformatf("v%0d_stalls", i), hif.stall_cycles, vecs[i].stalls);
         check($sformatf("v%0d_redirs", i), hif.redirects, vecs[i].redirs);
         tick();
      end

      // Asynchronous reset while stalled on $9.
      drive(1, 0, 0, 0, 0, 1, 9, 0);
      tick();
      drive(1, 9, 0, 1, 0, 0, 0, 0);
      tick();
      check("pre_rst_state", 16'(hif.state), 16'd1);
      check("pre_rst_ctrl",  16'(ctrl_now()), 16'b11100);
      #2;
      rst = 1'b0;
      #1;
      check("async_rst_ctrl",   16'(ctrl_now()), 16'd0);
      check("async_rst_state",  16'(hif.state), 16'd0);
      check("async_rst_stalls", hif.stall_cycles, 16'd0);
      check("async_rst_redirs", hif.redirects, 16'd0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_release_ctrl",  16'(ctrl_now()), 16'd0);
      tick();
      check("post_rst_state",  16'(hif.state), 16'd0);
      check("post_rst_stalls", hif.stall_cycles, 16'd0);

      // Stall counter saturation: each producer/consumer pair yields 3 stall cycles.
      for (int k = 0; k < 21846; k++) begin
         drive(1, 0, 0, 0, 0, 1, 8, 0);
         tick();
         drive(1, 8, 0, 1, 0, 0, 0, 0);
         tick();
         tick();
         tick();
         if (k == 21844) check("stalls_65535", hif.stall_cycles, 16'hFFFF);
      end
      check("stalls_saturated", hif.stall_cycles, 16'hFFFF);
      check("sat_redirs",       hif.redirects, 16'd0);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      check("sat_idle_ctrl", 16'(ctrl_now()), 16'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
